led_pulse_sched: RTL
====================

# led_pulse_sched

Round-robin scheduler that shares one LED pulse timer between NREQ requesters. Each accepted request produces one fixed-length LED on-pulse of 2^CTRLEN cycles, and the block reports which requester owns it. Requests arriving while the timer is busy are held pending and served in rotating-priority order. The block sits between the board's trigger sources (buttons, debug events) and the single status LED.

## Interface
- NREQ, 4: number of requesters, 2..8.
- CTRLEN, 27: on-pulse counter width; pulse length is 2^CTRLEN cycles.
- GAPLEN, 4: gap counter width; gap length is 2^GAPLEN cycles. Used only with the gap feature.
- CLK  in  1  single clock. All logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request. Sampled every cycle.
- led  out  1  LED drive. High only in ON.
- grant  out  NREQ  one-hot owner of the current pulse. Zero outside ON.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse in the first cycle after ON ends.
- debug  out  4  {state[1:0], last_idx[1:0]}.

## Operation
- State encoding:
  - IDLE = 2'b00
  - ON = 2'b01
  - GAP = 2'b10
  - 2'b11 is illegal; it returns to IDLE with all outputs at reset values.
- Pending register `pend[NREQ-1:0]`:
  - Every cycle, `pend <= pend | req`, except for the bit being granted.
  - The granted bit is cleared on the grant edge. It is re-set on that same edge if `req[g]` is high on that edge; set wins over clear.
- Arbitration:
  - Pointer `last_idx` starts at reset value NREQ-1.
  - Winner is the first set bit of `pend`, searching from `last_idx+1` upward with wrap modulo NREQ.
  - `last_idx` updates to the winner on the grant edge.
- IDLE:
  - led=0, grant=0, cnt=0.
  - If pend≠0, go to ON on the next edge and grant the winner.
  - `req` alone, with pend=0, does not grant in the same cycle.
- ON:
  - led=1, grant=one-hot(winner).
  - `cnt` increments by 1 each cycle, modulo 2^CTRLEN.
  - When the incremented value wraps to 0, leave ON: go to GAP with the feature enabled, otherwise to IDLE. Set done=1 for that next cycle.
- GAP:
  - led=0, grant=0.
  - `gcnt` increments and wraps like `cnt`; on wrap, go to IDLE.
  - Requests keep accumulating in `pend`.
- Arithmetic:
  - Counters are unsigned, fixed width, with wrap by natural overflow.
  - No saturation and no carry-out register.
- All outputs are registered.

## Timing
- Reset values: led=0, grant=0, busy=0, done=0, debug=4'b0011 for NREQ=4 (state IDLE, last_idx=NREQ-1 truncated). Also pend=0, cnt=0, gcnt=0.
- Reset is asynchronous. Asserting RST_N mid-pulse forces all of the above immediately, and pending requests are lost.
- Latency from req asserted (sampled at edge k, IDLE, pend=0):
  - pend set after edge k.
  - ON, led=1 and grant valid after edge k+1.
- Pulse length: led is high for exactly 2^CTRLEN cycles.
- After ON:
  - Without gap, busy falls together with led.
  - With gap, led stays 0 for 2^GAPLEN cycles plus 1 IDLE cycle before the next ON.
- Minimum spacing between pulses is one IDLE cycle, even with pend≠0.
- A requester holding req high continuously is re-queued. It is served again only after every other pending requester has had one turn.
- Simultaneous requests from all requesters are served in the order last_idx+1, +2, … in consecutive pulses.

## Configuration
- Macro: `LED_PULSE_SCHED_GAP_EN`.
- Defined:
  - GAP state and `gcnt` are built.
  - ON → GAP → IDLE.
  - The GAPLEN parameter is used.
- Undefined:
  - GAP state and `gcnt` are absent.
  - ON → IDLE.
  - GAPLEN is ignored.
  - State 2'b10 is treated as illegal.

## Structure
- Package `led_pulse_sched_pkg` holds:
  - the state encoding localparams IDLE/ON/GAP;
  - the debug field layout constants.
- Sub-module `rr_pick`: a combinational round-robin picker with inputs pend and last_idx, and outputs a valid flag, the winner index and the one-hot winner.
- The top level holds the FSM, counters, pend and the output registers.

## Test plan
All scenarios use CTRLEN=4 and GAPLEN=2.
- Reset then single request: release RST_N, then pulse req=4'b0001 for 1 cycle → led high 2 cycles later for exactly 16 cycles, grant=0001, done pulse 1 cycle after led falls.
- Simultaneous requests: req=4'b1111 for 1 cycle → pulses granted 0001, 0010, 0100, 1000 in order, each 16 cycles, and no extra pulse.
- Fairness: req[0] held high, req[2] pulsed once during the first pulse → grants 0001, 0100, 0001, 0001, ….
- Gap feature, macro defined: two back-to-back requests → 4 GAP cycles plus 1 IDLE cycle with led=0 between pulses. Without the macro → exactly 1 cycle with led=0.
- Reset mid-pulse: assert RST_N low at cnt=7 with pend=4'b0110 → led=0, grant=0, busy=0 immediately. After release, no pulse occurs.
- Illegal state forced to 2'b11 → next edge is IDLE with led=0 and grant=0.

Source files
------------

// File: rtl/led_pulse_sched_pkg.sv
// Shared encodings for the LED pulse scheduler: FSM state values and debug-port layout.
package led_pulse_sched_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ON   = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ON      = ON,
        ST_GAP     = GAP,
        ST_ILLEGAL = 2'b11
    } state_e;

    // debug = {state[1:0], last_idx[1:0]}
    localparam int DBG_W         = 4;
    localparam int DBG_STATE_LSB = 2;
    localparam int DBG_IDX_W     = 2;

endpackage

// File: rtl/led_pulse_sched_if.sv
// Requester/LED side bundle of the LED pulse scheduler.
interface led_pulse_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            led;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            done;
    logic [3:0]      debug;

    modport master (output req, input led, input grant, input busy, input done, input debug);
    modport slave  (input req, output led, output grant, output busy, output done, output debug);
endinterface

// File: rtl/led_pulse_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching upward from last_idx+1.
module led_pulse_sched_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] pend,
    input  logic [IDXW-1:0] last_idx,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] onehot
);

    logic [IDXW:0]   sum_s;
    logic [IDXW-1:0] cand_s;

    // Scan offsets 1..NREQ; the extra sum bit keeps the modulo-NREQ wrap exact for non-power-of-2 NREQ
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        sum_s  = '0;
        cand_s = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum_s = {1'b0, last_idx} + (IDXW+1)'(off);
            if (sum_s >= (IDXW+1)'(NREQ)) begin
                sum_s = sum_s - (IDXW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDXW-1:0];
            if (!valid && pend[cand_s]) begin
                valid  = 1'b1;
                idx    = cand_s;
                onehot = NREQ'(1) << cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/led_pulse_sched.sv
// Shares one LED pulse timer between NREQ requesters with round-robin priority.
// Optional post-pulse gap state is built when LED_PULSE_SCHED_GAP_EN is defined.
module led_pulse_sched
    import led_pulse_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int CTRLEN = 27,
    parameter int GAPLEN = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    led_pulse_sched_if.slave   bus
);

    localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [CTRLEN-1:0] cnt_q, cnt_d;
`ifdef LED_PULSE_SCHED_GAP_EN
    logic [GAPLEN-1:0] gcnt_q, gcnt_d;
`endif
    logic [NREQ-1:0]   pend_q, pend_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   last_idx_q, last_idx_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pick_valid_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic [NREQ-1:0]   pick_onehot_s;
    logic [DBG_IDX_W-1:0] dbg_idx_s;

    led_pulse_sched_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .pend     (pend_q),
        .last_idx (last_idx_q),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s),
        .onehot   (pick_onehot_s)
    );

    // Next-state, counters, pending set and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
`ifdef LED_PULSE_SCHED_GAP_EN
        gcnt_d     = gcnt_q;
`endif
        pend_d     = pend_q | bus.req;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        led_d      = led_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                led_d   = 1'b0;
                grant_d = '0;
`ifdef LED_PULSE_SCHED_GAP_EN
                gcnt_d  = '0;
`endif
                // Arbitrate on registered pend only, so a fresh req needs one cycle to land
                if (pick_valid_s) begin
                    state_d    = ST_ON;
                    led_d      = 1'b1;
                    grant_d    = pick_onehot_s;
                    last_idx_d = pick_idx_s;
                    pend_d     = (pend_q & ~pick_onehot_s) | bus.req;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                cnt_d = cnt_q + CTRLEN'(1);
                led_d = 1'b1;
                if (&cnt_q) begin
`ifdef LED_PULSE_SCHED_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                    led_d   = 1'b0;
                    grant_d = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ON;
                end
            end
`ifdef LED_PULSE_SCHED_GAP_EN
            ST_GAP: begin
                gcnt_d  = gcnt_q + GAPLEN'(1);
                led_d   = 1'b0;
                grant_d = '0;
                if (&gcnt_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
`ifdef LED_PULSE_SCHED_GAP_EN
                gcnt_d     = '0;
`endif
                grant_d    = '0;
                last_idx_d = LAST_RST;
                led_d      = 1'b0;
                done_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, pending set and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
`ifdef LED_PULSE_SCHED_GAP_EN
            gcnt_q     <= '0;
`endif
            pend_q     <= '0;
            grant_q    <= '0;
            last_idx_q <= LAST_RST;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
`ifdef LED_PULSE_SCHED_GAP_EN
            gcnt_q     <= gcnt_d;
`endif
            pend_q     <= pend_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    if (IDXW >= DBG_IDX_W) begin : g_dbg_trunc
        assign dbg_idx_s = last_idx_q[DBG_IDX_W-1:0];
    end else begin : g_dbg_ext
        assign dbg_idx_s = {1'b0, last_idx_q};
    end

    assign bus.led   = led_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.debug = {state_q, dbg_idx_s};

endmodule
